// File: rtl/bcd_combine.sv
// Sequential packed-BCD to binary converter: rebuilds the binary value of NDIG
// BCD digits by multiply-by-10-and-add, most significant digit first.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | ready for a new word; a valid_i captures bcd_i
// S_CONV | one digit folded into the accumulator per clock, MS first
// S_DONE | result presented on bin_o/err_o with valid_o until ready_i
module bcd_combine #(
    parameter int NDIG = 2,
    parameter int W    = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [4*NDIG-1:0]   bcd_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [W-1:0]        bin_o,
    output logic                err_o
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [4*NDIG-1:0]   cap_q, cap_d;
    logic [W-1:0]        acc_q, acc_d;
    logic [W-1:0]        bin_q, bin_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                err_q, err_d;
    logic                err_out_q, err_out_d;
    logic                valid_q, valid_d;

    logic [3:0]          digit;
    logic                digit_bad;
    logic [W-1:0]        acc_next;

    always_comb begin
        digit     = cap_q[4*idx_q +: 4];
        digit_bad = (digit > 4'd9);
        // Out-of-range digits still contribute their raw value; only err flags them.
        acc_next  = (acc_q << 3) + (acc_q << 1) + W'(digit);
    end

    always_comb begin
        state_d   = state_q;
        cap_d     = cap_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        err_d     = err_q;
        bin_d     = bin_q;
        err_out_d = err_out_q;
        valid_d   = valid_q;
        ready_o   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    cap_d   = bcd_i;
                    acc_d   = '0;
                    idx_d   = IW'(NDIG - 1);
                    err_d   = 1'b0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                acc_d = acc_next;
                if (digit_bad) begin
                    err_d = 1'b1;
                end
                if (idx_q == '0) begin
                    bin_d     = acc_next;
                    err_out_d = err_q | digit_bad;
                    valid_d   = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cap_q     <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            bin_q     <= '0;
            err_out_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            bin_q     <= bin_d;
            err_out_q <= err_out_d;
            valid_q   <= valid_d;
        end
    end

    // Result registers are separate from the accumulator so bin_o/err_o hold after handoff.
    assign bin_o   = bin_q;
    assign err_o   = err_out_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_bcd_combine.sv
// Bench for bcd_combine: a 2-digit and a 4-digit instance checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_bcd_combine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        va_i = 1'b0, rdya_i = 1'b1, rdyoa, vaoa, erra;
    logic [7:0]  bcda_i = '0;
    logic [6:0]  bina;

    logic        vb_i = 1'b0, rdyb_i = 1'b1, rdyob, vaob, errb;
    logic [15:0] bcdb_i = '0;
    logic [13:0] binb;

    bcd_combine #(.NDIG(2), .W(7)) dut_a (
        .clk(clk), .rst_n(rst_n), .valid_i(va_i), .ready_o(rdyoa), .bcd_i(bcda_i),
        .valid_o(vaoa), .ready_i(rdya_i), .bin_o(bina), .err_o(erra));

    bcd_combine #(.NDIG(4), .W(14)) dut_b (
        .clk(clk), .rst_n(rst_n), .valid_i(vb_i), .ready_o(rdyob), .bcd_i(bcdb_i),
        .valid_o(vaob), .ready_i(rdyb_i), .bin_o(binb), .err_o(errb));

    int n_tests = 0;
    int n_fail  = 0;
    bit run_cmp = 1'b1;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Decimal value of the digit string (MS first) reduced mod 2^w; e flags digits > 9.
    function automatic int unsigned conv(input logic [15:0] b, input int nd, input int w,
                                         output bit e);
        int unsigned v = 0;
        int unsigned d;
        e = 1'b0;
        for (int k = nd - 1; k >= 0; k--) begin
            d = (b >> (4 * k)) & 16'hF;
            v = v * 10 + d;
            if (d > 9) e = 1'b1;
        end
        return v % (32'd1 << w);
    endfunction

    // Transaction model: a result appears NDIG clocks after acceptance and is held until taken.
    int          ma_cnt = 0, mb_cnt = 0;
    bit          ma_valid = 0, mb_valid = 0, ma_err = 0, mb_err = 0, ma_perr, mb_perr;
    int unsigned ma_bin = 0, mb_bin = 0, ma_pend, mb_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_cnt = 0; ma_valid = 0; ma_bin = 0; ma_err = 0;
        end else if (ma_valid) begin
            if (rdya_i) ma_valid = 0;
        end else if (ma_cnt > 0) begin
            ma_cnt--;
            if (ma_cnt == 0) begin
                ma_valid = 1; ma_bin = ma_pend; ma_err = ma_perr;
            end
        end else if (va_i) begin
            ma_cnt  = 2;
            ma_pend = conv(16'(bcda_i), 2, 7, ma_perr);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mb_cnt = 0; mb_valid = 0; mb_bin = 0; mb_err = 0;
        end else if (mb_valid) begin
            if (rdyb_i) mb_valid = 0;
        end else if (mb_cnt > 0) begin
            mb_cnt--;
            if (mb_cnt == 0) begin
                mb_valid = 1; mb_bin = mb_pend; mb_err = mb_perr;
            end
        end else if (vb_i) begin
            mb_cnt  = 4;
            mb_pend = conv(bcdb_i, 4, 14, mb_perr);
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("a_ready", rdyoa, (!ma_valid && ma_cnt == 0));
            chk("a_valid", vaoa, ma_valid);
            chk("a_bin",   bina, ma_bin);
            chk("a_err",   erra, ma_err);
            chk("b_ready", rdyob, (!mb_valid && mb_cnt == 0));
            chk("b_valid", vaob, mb_valid);
            chk("b_bin",   binb, mb_bin);
            chk("b_err",   errb, mb_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_a(input logic [7:0] d);
        va_i = 1'b1; bcda_i = d;
        step();
        va_i = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] d);
        vb_i = 1'b1; bcdb_i = d;
        step();
        vb_i = 1'b0;
    endtask

    task automatic wait_a(output int lat);
        lat = 0;
        while (!vaoa && lat < 20) begin step(); lat++; end
        if (!vaoa) chk("a_timeout", 0, 1);
    endtask

    task automatic wait_b(output int lat);
        lat = 0;
        while (!vaob && lat < 20) begin step(); lat++; end
        if (!vaob) chk("b_timeout", 0, 1);
    endtask

    int lat;

    initial begin
        repeat (3) step();
        chk("rst_ready", rdyoa, 1);
        chk("rst_valid", vaoa, 0);
        chk("rst_bin",   bina, 0);
        chk("rst_err",   erra, 0);
        rst_n = 1'b1;
        step();

        // 45 -> 45, latency 2, drops after one cycle with ready_i high
        send_a(8'h45);
        wait_a(lat);
        chk("t1_lat", lat, 2);
        chk("t1_bin", bina, 45);
        chk("t1_err", erra, 0);
        step();
        chk("t1_drop",  vaoa, 0);
        chk("t1_ready", rdyoa, 1);

        // back-to-back 99 then 00 with valid_i held high
        va_i = 1'b1; bcda_i = 8'h99;
        step();
        bcda_i = 8'h00;
        wait_a(lat);
        chk("t2_bin0", bina, 99);
        step();
        wait_a(lat);
        chk("t2_gap",  lat, 3);
        chk("t2_bin1", bina, 0);
        va_i = 1'b0;
        step();

        // bad digit keeps raw value and sets err; next clean word clears it
        send_a(8'h1A);
        wait_a(lat);
        chk("t3_bin", bina, 20);
        chk("t3_err", erra, 1);
        step();
        send_a(8'h07);
        wait_a(lat);
        chk("t3_bin2", bina, 7);
        chk("t3_err2", erra, 0);
        step();

        // backpressure: result held 5 clocks
        rdya_i = 1'b0;
        send_a(8'h59);
        wait_a(lat);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_v", vaoa, 1);
            chk("t4_hold_b", bina, 59);
            chk("t4_hold_r", rdyoa, 0);
        end
        rdya_i = 1'b1;
        step();
        chk("t4_drop",  vaoa, 0);
        chk("t4_ready", rdyoa, 1);
        chk("t4_keep",  bina, 59);

        // reset mid-conversion aborts
        send_a(8'h37);
        rst_n = 1'b0;
        step();
        chk("t5_valid", vaoa, 0);
        chk("t5_bin",   bina, 0);
        chk("t5_err",   erra, 0);
        chk("t5_ready", rdyoa, 1);
        rst_n = 1'b1;
        step();
        send_a(8'h12);
        wait_a(lat);
        chk("t5_bin2", bina, 12);
        step();

        // both digits bad: 15*10+15 = 165 wraps mod 128 to 37
        send_a(8'hFF);
        wait_a(lat);
        chk("tx_bin", bina, 37);
        chk("tx_err", erra, 1);
        step();

        // 4-digit instance
        send_b(16'h9999);
        wait_b(lat);
        chk("t6_lat", lat, 4);
        chk("t6_bin", binb, 9999);
        chk("t6_err", errb, 0);
        step();
        send_b(16'h0100);
        wait_b(lat);
        chk("t6_bin2", binb, 100);
        step();
        repeat (2) step();

        run_cmp = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
